// File: rtl/ldq_alloc_ctrl_pkg.sv
// Shared types and constants for the load-queue pointer controller.
// Includes the occupancy-limited SIZE helper used by every pointer adder.
package ldq_alloc_ctrl_pkg;

    localparam int DEPTH            = 32;
    localparam int INDEX            = 5;
    localparam int NUM_PARTS        = 4;
    localparam int NUM_PARTS_LOG    = 2;
    localparam int ALLOC_WIDTH      = 2;
    localparam int COMMIT_WIDTH     = 2;
    localparam int ENTRIES_PER_PART = DEPTH / NUM_PARTS;

    typedef logic [INDEX-1:0]     ldq_idx_t;
    typedef logic [INDEX:0]       ldq_cnt_t;
    typedef logic [NUM_PARTS-1:0] ldq_mask_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } ldq_fsm_e;

    // Effective queue size: number of active partitions times their depth.
    function automatic ldq_cnt_t part_size(input ldq_mask_t mask);
        ldq_cnt_t n;
        n = '0;
        for (int i = 0; i < (1 << NUM_PARTS_LOG); i++) begin
            if (mask[i]) n = n + ldq_cnt_t'(ENTRIES_PER_PART);
        end
        return n;
    endfunction

endpackage

// File: rtl/ldq_alloc_ctrl_ptr_wrap_add.sv
// (ptr + inc) mod size for inc in 0..2; size need not be a power of two.
// A single conditional subtract suffices because ptr < size and inc < size.
module ldq_ptr_wrap_add
    import ldq_alloc_ctrl_pkg::*;
(
    input  ldq_idx_t   i_ptr,
    input  logic [1:0] i_inc,
    input  ldq_cnt_t   i_size,
    output ldq_idx_t   o_ptr
);

    ldq_cnt_t w_sum;
    ldq_cnt_t w_wrap;

    assign w_sum  = {1'b0, i_ptr} + {{(INDEX-1){1'b0}}, i_inc};
    assign w_wrap = w_sum - i_size;
    assign o_ptr  = (w_sum >= i_size) ? w_wrap[INDEX-1:0] : w_sum[INDEX-1:0];

endmodule

// File: rtl/ldq_alloc_ctrl.sv
// Load-queue allocation/commit pointer controller with drain-then-switch partition reconfiguration.
// Optional stall statistics counters are built when LDQ_STALL_STATS_EN is defined.
module ldq_alloc_ctrl
    import ldq_alloc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  ldq_mask_t  lsqPartitionActive_i,
    input  logic [1:0] allocCnt_i,
    output ldq_idx_t   allocIdx0_o,
    output ldq_idx_t   allocIdx1_o,
    output logic       ldqStall_o,
    input  logic [1:0] commitCnt_i,
    input  logic       recover_i,
    input  ldq_idx_t   recoverTail_i,
    output ldq_idx_t   rdAddr0_o,
    output ldq_idx_t   rdAddr1_o,
    output ldq_cnt_t   ldqCount_o,
    output ldq_mask_t  partitionActive_o,
    output logic       reconfigBusy_o
`ifdef LDQ_STALL_STATS_EN
    ,
    output logic [31:0] fullStallCycles_o,
    output logic [31:0] reconfigStallCycles_o
`endif
);

    ldq_fsm_e   r_state;
    ldq_fsm_e   w_state_nxt;
    ldq_idx_t   r_head;
    ldq_idx_t   r_tail;
    ldq_cnt_t   r_count;
    ldq_mask_t  r_mask;

    ldq_idx_t   w_head_nxt;
    ldq_idx_t   w_tail_nxt;
    ldq_cnt_t   w_count_nxt;
    ldq_mask_t  w_mask_nxt;

    ldq_cnt_t   w_size;
    ldq_cnt_t   w_free;
    logic       w_occ_stall;
    logic       w_stall;
    logic       w_busy;
    logic [1:0] w_alloc_eff;
    ldq_idx_t   w_head_adv;
    ldq_idx_t   w_tail_adv;
    ldq_idx_t   w_head_p1;
    ldq_idx_t   w_tail_p1;
    ldq_cnt_t   w_rec_diff;

    assign w_size      = part_size(r_mask);
    assign w_free      = w_size - r_count;
    // Stall uses the current count, so a full queue stalls even when a commit frees space this cycle.
    assign w_occ_stall = (w_free < ldq_cnt_t'(ALLOC_WIDTH));
    assign w_alloc_eff = w_stall ? 2'd0 : allocCnt_i;

    ldq_ptr_wrap_add u_tail_adv (.i_ptr(r_tail), .i_inc(w_alloc_eff), .i_size(w_size), .o_ptr(w_tail_adv));
    ldq_ptr_wrap_add u_head_adv (.i_ptr(r_head), .i_inc(commitCnt_i), .i_size(w_size), .o_ptr(w_head_adv));
    ldq_ptr_wrap_add u_head_p1  (.i_ptr(r_head), .i_inc(2'd1),        .i_size(w_size), .o_ptr(w_head_p1));
    ldq_ptr_wrap_add u_tail_p1  (.i_ptr(r_tail), .i_inc(2'd1),        .i_size(w_size), .o_ptr(w_tail_p1));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b1;
        w_busy      = 1'b1;
        unique case (r_state)
            RUN: begin
                w_stall = w_occ_stall;
                w_busy  = 1'b0;
                if (lsqPartitionActive_i != r_mask) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (lsqPartitionActive_i == r_mask) w_state_nxt = RUN;
                else if (r_count == '0)             w_state_nxt = SWITCH;
            end
            SWITCH:  w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Recovered occupancy is the wrapped distance from the post-commit head to the restored tail.
    assign w_rec_diff = {1'b0, recoverTail_i} - {1'b0, w_head_adv};

    always_comb begin
        w_head_nxt  = w_head_adv;
        w_tail_nxt  = w_tail_adv;
        w_count_nxt = r_count + ldq_cnt_t'(w_alloc_eff) - ldq_cnt_t'(commitCnt_i);
        w_mask_nxt  = r_mask;
        if (r_state == SWITCH) begin
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
            w_mask_nxt  = lsqPartitionActive_i;
        end else if (recover_i) begin
            w_tail_nxt  = recoverTail_i;
            w_count_nxt = (recoverTail_i >= w_head_adv) ? w_rec_diff : (w_rec_diff + w_size);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_mask  <= '1;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    assign allocIdx0_o       = r_tail;
    assign allocIdx1_o       = w_tail_p1;
    assign rdAddr0_o         = r_head;
    assign rdAddr1_o         = w_head_p1;
    assign ldqCount_o        = r_count;
    assign partitionActive_o = r_mask;
    assign ldqStall_o        = w_stall;
    assign reconfigBusy_o    = w_busy;

    a_commit_le_count: assert property (@(posedge clk) disable iff (reset)
        (ldq_cnt_t'(commitCnt_i) <= r_count) && (int'(commitCnt_i) <= COMMIT_WIDTH));

`ifdef LDQ_STALL_STATS_EN
    logic [31:0] r_full_stalls;
    logic [31:0] r_reconf_stalls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full_stalls   <= '0;
            r_reconf_stalls <= '0;
        end else begin
            if ((r_state == RUN) && w_occ_stall && (r_full_stalls != '1))
                r_full_stalls <= r_full_stalls + 32'd1;
            if ((r_state != RUN) && (r_reconf_stalls != '1))
                r_reconf_stalls <= r_reconf_stalls + 32'd1;
        end
    end

    assign fullStallCycles_o     = r_full_stalls;
    assign reconfigStallCycles_o = r_reconf_stalls;
`endif

endmodule

// File: tb/tb_ldq_alloc_ctrl.sv
// Self-checking bench for ldq_alloc_ctrl: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model of the queue.
module tb_ldq_alloc_ctrl;

    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_SWITCH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] lsqPartitionActive_i;
    logic [1:0] allocCnt_i;
    logic [4:0] allocIdx0_o, allocIdx1_o;
    logic       ldqStall_o;
    logic [1:0] commitCnt_i;
    logic       recover_i;
    logic [4:0] recoverTail_i;
    logic [4:0] rdAddr0_o, rdAddr1_o;
    logic [5:0] ldqCount_o;
    logic [3:0] partitionActive_o;
    logic       reconfigBusy_o;
`ifdef LDQ_STALL_STATS_EN
    logic [31:0] fullStallCycles_o, reconfigStallCycles_o;
`endif

    ldq_alloc_ctrl dut (
        .clk(clk), .reset(reset),
        .lsqPartitionActive_i(lsqPartitionActive_i),
        .allocCnt_i(allocCnt_i), .allocIdx0_o(allocIdx0_o), .allocIdx1_o(allocIdx1_o),
        .ldqStall_o(ldqStall_o), .commitCnt_i(commitCnt_i),
        .recover_i(recover_i), .recoverTail_i(recoverTail_i),
        .rdAddr0_o(rdAddr0_o), .rdAddr1_o(rdAddr1_o), .ldqCount_o(ldqCount_o),
        .partitionActive_o(partitionActive_o), .reconfigBusy_o(reconfigBusy_o)
`ifdef LDQ_STALL_STATS_EN
        , .fullStallCycles_o(fullStallCycles_o), .reconfigStallCycles_o(reconfigStallCycles_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_head, m_tail, m_count, m_mode;
    logic [3:0] m_mask;
    int         m_full_stalls, m_reconf_stalls;
    logic [3:0] req_mask;

    function automatic int m_size();
        return $countones(m_mask) * 8;
    endfunction

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_count = 0; m_mode = M_RUN; m_mask = 4'b1111;
        m_full_stalls = 0; m_reconf_stalls = 0;
    endtask

    task automatic model_step(input int a, input int c, input bit r, input int rt, input logic [3:0] req);
        int  size;
        int  cnt0;
        bit  occ;
        bit  stall;
        size  = m_size();
        cnt0  = m_count;
        occ   = (size - m_count) < 2;
        stall = (m_mode != M_RUN) || occ;
        if (m_mode == M_RUN && occ) m_full_stalls++;
        if (m_mode != M_RUN) m_reconf_stalls++;
        if (m_mode == M_SWITCH) begin
            m_mask = req; m_head = 0; m_tail = 0; m_count = 0; m_mode = M_RUN;
            return;
        end
        m_head = (m_head + c) % size;
        if (r) begin
            m_tail  = rt;
            m_count = (rt - m_head + size) % size;
        end else begin
            if (!stall) begin
                m_tail  = (m_tail + a) % size;
                m_count = m_count + a;
            end
            m_count = m_count - c;
        end
        if (m_mode == M_RUN) begin
            if (req != m_mask) m_mode = M_DRAIN;
        end else if (req == m_mask) m_mode = M_RUN;
        else if (cnt0 == 0) m_mode = M_SWITCH;
    endtask

    function automatic logic [31:0] model_vec();
        int size;
        bit stall;
        size  = m_size();
        stall = (m_mode != M_RUN) || ((size - m_count) < 2);
        return {5'(m_tail), 5'((m_tail + 1) % size), 5'(m_head), 5'((m_head + 1) % size),
                6'(m_count), m_mask, stall, (m_mode != M_RUN)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {allocIdx0_o, allocIdx1_o, rdAddr0_o, rdAddr1_o, ldqCount_o,
                partitionActive_o, ldqStall_o, reconfigBusy_o};
    endfunction

    // Drive one cycle from a falling edge, advance the model at the rising edge, return at the next falling edge.
    task automatic tick(input int a, input int c, input bit r, input int rt);
        allocCnt_i           = 2'(a);
        commitCnt_i          = 2'(c);
        recover_i            = r;
        recoverTail_i        = 5'(rt);
        lsqPartitionActive_i = req_mask;
        @(posedge clk);
        model_step(a, c, r, rt, req_mask);
        @(negedge clk);
        allocCnt_i  = 2'd0;
        commitCnt_i = 2'd0;
        recover_i   = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_mask = 4'b1111;
        lsqPartitionActive_i = 4'b1111;
        allocCnt_i = 2'd0; commitCnt_i = 2'd0; recover_i = 1'b0; recoverTail_i = 5'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_errors++; $display("FAIL reset_state: got %h want %h", dut_vec(), model_vec());
        end
        n_checks++;
        if (rdAddr1_o !== 5'd1 || ldqStall_o !== 1'b0 || partitionActive_o !== 4'b1111) begin
            n_errors++; $display("FAIL reset_outputs: rd1=%0d stall=%0b mask=%b want 1 0 1111",
                                 rdAddr1_o, ldqStall_o, partitionActive_o);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (allocIdx0_o !== 5'(2 * i) || allocIdx1_o !== 5'(2 * i + 1) || ldqStall_o !== 1'b0) begin
                n_errors++; $display("FAIL fill_idx[%0d]: got %0d,%0d stall=%0b want %0d,%0d stall=0",
                                     i, allocIdx0_o, allocIdx1_o, ldqStall_o, 2 * i, 2 * i + 1);
            end
            tick(2, 0, 0, 0);
        end
        n_checks++;
        if (ldqCount_o !== 6'd32 || ldqStall_o !== 1'b1) begin
            n_errors++; $display("FAIL fill_full: count=%0d stall=%0b want 32 1", ldqCount_o, ldqStall_o);
        end
        tick(2, 0, 0, 0);
        n_checks++;
        if (ldqCount_o !== 6'd32 || dut_vec() !== model_vec()) begin
            n_errors++; $display("FAIL fill_hold: got %h want %h", dut_vec(), model_vec());
        end
        tick(2, 2, 0, 0);
        n_checks++;
        if (ldqCount_o !== 6'd30 || rdAddr0_o !== 5'd2 || allocIdx0_o !== 5'd0) begin
            n_errors++; $display("FAIL full_commit: count=%0d head=%0d tail=%0d want 30 2 0",
                                 ldqCount_o, rdAddr0_o, allocIdx0_o);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        req_mask = 4'b0011;
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        n_checks++;
        if (partitionActive_o !== 4'b0011 || reconfigBusy_o !== 1'b0 || dut_vec() !== model_vec()) begin
            n_errors++; $display("FAIL wrap_setup: got %h want %h", dut_vec(), model_vec());
        end
        for (int i = 0; i < 7; i++) tick(2, 0, 0, 0);
        tick(1, 0, 0, 0);
        n_checks++;
        if (allocIdx0_o !== 5'd15 || allocIdx1_o !== 5'd0 || ldqStall_o !== 1'b1) begin
            n_errors++; $display("FAIL wrap_alloc1: idx0=%0d idx1=%0d stall=%0b want 15 0 1",
                                 allocIdx0_o, allocIdx1_o, ldqStall_o);
        end
        for (int i = 0; i < 7; i++) tick(0, 2, 0, 0);
        tick(0, 1, 0, 0);
        n_checks++;
        if (rdAddr0_o !== 5'd15 || rdAddr1_o !== 5'd0 || ldqCount_o !== 6'd0) begin
            n_errors++; $display("FAIL wrap_rd1: rd0=%0d rd1=%0d count=%0d want 15 0 0",
                                 rdAddr0_o, rdAddr1_o, ldqCount_o);
        end
        tick(1, 0, 0, 0);
        n_checks++;
        if (allocIdx0_o !== 5'd0 || ldqCount_o !== 6'd1 || dut_vec() !== model_vec()) begin
            n_errors++; $display("FAIL wrap_tail: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 5; i++) tick(2, 0, 0, 0);
        tick(2, 2, 0, 0);
        n_checks++;
        if (ldqCount_o !== 6'd10 || rdAddr0_o !== 5'd2 || allocIdx0_o !== 5'd12) begin
            n_errors++; $display("FAIL alloc_commit: count=%0d head=%0d tail=%0d want 10 2 12",
                                 ldqCount_o, rdAddr0_o, allocIdx0_o);
        end
    endtask

    task automatic test_recover();
        apply_reset();
        for (int i = 0; i < 3; i++) tick(2, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 2, 0, 0);
        tick(2, 1, 1, 5);
        n_checks++;
        if (allocIdx0_o !== 5'd5 || rdAddr0_o !== 5'd4 || ldqCount_o !== 6'd1) begin
            n_errors++; $display("FAIL recover: tail=%0d head=%0d count=%0d want 5 4 1",
                                 allocIdx0_o, rdAddr0_o, ldqCount_o);
        end
    endtask

    task automatic test_reconfig();
        int stall_cycles;
        apply_reset();
        for (int i = 0; i < 3; i++) tick(2, 0, 0, 0);
        req_mask = 4'b0011;
        stall_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            tick(0, (m_count < 2) ? m_count : 2, 0, 0);
            if (ldqStall_o === 1'b1) stall_cycles++;
        end
        n_checks++;
        if (stall_cycles !== 4) begin
            n_errors++; $display("FAIL reconfig_stall_cycles: got %0d want 4", stall_cycles);
        end
        n_checks++;
        if (partitionActive_o !== 4'b0011 || rdAddr0_o !== 5'd0 || allocIdx0_o !== 5'd0) begin
            n_errors++; $display("FAIL reconfig_final: mask=%b head=%0d tail=%0d want 0011 0 0",
                                 partitionActive_o, rdAddr0_o, allocIdx0_o);
        end
        // Request reverts to the committed mask while draining: no switch happens.
        tick(2, 0, 0, 0);
        req_mask = 4'b1111;
        tick(0, 0, 0, 0);
        req_mask = 4'b0011;
        tick(0, 0, 0, 0);
        n_checks++;
        if (reconfigBusy_o !== 1'b0 || partitionActive_o !== 4'b0011 || ldqCount_o !== 6'd2) begin
            n_errors++; $display("FAIL reconfig_revert: busy=%0b mask=%b count=%0d want 0 0011 2",
                                 reconfigBusy_o, partitionActive_o, ldqCount_o);
        end
    endtask

    task automatic test_reset_drain();
        req_mask = 4'b0001;
        tick(0, 0, 0, 0);
        n_checks++;
        if (reconfigBusy_o !== 1'b1 || ldqCount_o === 6'd0) begin
            n_errors++; $display("FAIL drain_entry: busy=%0b count=%0d want 1 nonzero", reconfigBusy_o, ldqCount_o);
        end
        #2;
        reset = 1'b1;
        req_mask = 4'b1111;
        lsqPartitionActive_i = 4'b1111;
        model_reset();
        #1;
        n_checks++;
        if (partitionActive_o !== 4'b1111 || reconfigBusy_o !== 1'b0 || ldqCount_o !== 6'd0 ||
            dut_vec() !== model_vec()) begin
            n_errors++; $display("FAIL async_reset: got %h want %h", dut_vec(), model_vec());
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] masks [4];
        masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b0111; masks[3] = 4'b1111;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            int a, c, rt;
            bit r;
            a  = $urandom_range(2, 0);
            c  = $urandom_range((m_count < 2) ? m_count : 2, 0);
            r  = (m_mode == M_RUN) && ($urandom_range(19, 0) == 0);
            rt = $urandom_range(m_size() - 1, 0);
            if ($urandom_range(59, 0) == 0) req_mask = masks[$urandom_range(3, 0)];
            tick(a, c, r, rt);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
`ifdef LDQ_STALL_STATS_EN
        n_checks++;
        if (fullStallCycles_o !== 32'(m_full_stalls) || reconfigStallCycles_o !== 32'(m_reconf_stalls)) begin
            n_errors++; $display("FAIL stall_stats: got %0d,%0d want %0d,%0d", fullStallCycles_o,
                                 reconfigStallCycles_o, m_full_stalls, m_reconf_stalls);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_recover();
        test_reconfig();
        test_reset_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
